// File: rtl/dvid_pkg.sv
// Shared constants for the DVI TMDS encoder.
//   SYM_W       : TMDS symbol width (10 bits, bit 0 transmitted first)
//   CNT_W       : running-disparity counter width (6-bit two's complement)
//   CTL_SYM_xx  : control symbols sent during blanking, indexed by {c1, c0}
//   CLK_SYM     : fixed pattern for the TMDS clock lane
//   ctl_symbol(): maps a 2-bit control code to its symbol
package dvid_pkg;

  localparam int SYM_W = 10;
  localparam int CNT_W = 6;

  typedef logic [SYM_W-1:0] symbol_t;

  localparam symbol_t CTL_SYM_00 = 10'b1101010100;
  localparam symbol_t CTL_SYM_01 = 10'b0010101011;
  localparam symbol_t CTL_SYM_10 = 10'b0101010100;
  localparam symbol_t CTL_SYM_11 = 10'b1010101011;
  localparam symbol_t CLK_SYM    = 10'b0000011111;

  function automatic symbol_t ctl_symbol(input logic [1:0] ctl);
    symbol_t sym;
    case (ctl)
      2'b00:   sym = CTL_SYM_00;
      2'b01:   sym = CTL_SYM_01;
      2'b10:   sym = CTL_SYM_10;
      default: sym = CTL_SYM_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// Two-stage single-lane TMDS 8b/10b encoder.
//   Stage 1: transition minimisation (XOR / XNOR chain) -> q_m[8:0].
//   Stage 2: DC balance via running disparity, or control symbol when blanking.
// Ports:
//   clk, reset_n (async, active low), ce (clock enable, freezes both stages)
//   ctl[1:0]  control code sent while blank=1
//   data[7:0] pixel data for this lane
//   blank     1 = control period
//   symbol    10-bit registered output symbol
// Build option: DVID_DC_BALANCE_EN enables the running-disparity logic;
// without it active symbols are {1'b0, q_m[8], q_m[7:0]}.
module tmds_channel_encoder
  import dvid_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [1:0]       ctl,
  input  logic [7:0]       data,
  input  logic             blank,
  output logic [SYM_W-1:0] symbol
);

  // ---------------- stage 1: transition minimisation ----------------
  logic [3:0] data_ones;
  logic       use_xnor;
  logic [8:0] q_m_d;

  always_comb begin
    data_ones = '0;
    for (int i = 0; i < 8; i++) data_ones = data_ones + {3'b000, data[i]};
    // Ties (four ones) go to XNOR only when bit 0 is zero.
    use_xnor = (data_ones > 4'd4) || ((data_ones == 4'd4) && !data[0]);
    q_m_d    = '0;
    q_m_d[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data[i]) : (q_m_d[i-1] ^ data[i]);
    end
    q_m_d[8] = ~use_xnor;
  end

  logic [8:0] q_m_r;
  logic       blank_r;
  logic [1:0] ctl_r;

  // Reset state is a blank period with ctl=00 so the first output after
  // reset is the idle control symbol.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_m_r   <= '0;
      blank_r <= 1'b1;
      ctl_r   <= 2'b00;
    end else if (ce) begin
      q_m_r   <= q_m_d;
      blank_r <= blank;
      ctl_r   <= ctl;
    end
  end

  // ---------------- stage 2: DC balance / control ----------------
  logic [SYM_W-1:0] active_sym;

`ifdef DVID_DC_BALANCE_EN
  logic [3:0]              qm_ones;
  logic [3:0]              n1_r;
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_next;
  logic signed [CNT_W-1:0] diff;

  always_comb begin
    qm_ones = '0;
    for (int i = 0; i < 8; i++) qm_ones = qm_ones + {3'b000, q_m_d[i]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  n1_r <= '0;
    else if (ce)   n1_r <= qm_ones;
  end

  always_comb begin
    // n1 - n0 with n0 = 8 - n1, i.e. 2*n1 - 8.
    diff       = $signed({1'b0, n1_r, 1'b0}) - 6'sd8;
    active_sym = '0;
    cnt_next   = cnt;
    if ((cnt == '0) || (n1_r == 4'd4)) begin
      active_sym = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
      cnt_next   = q_m_r[8] ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[CNT_W-1] && (n1_r > 4'd4)) ||
                 ( cnt[CNT_W-1] && (n1_r < 4'd4))) begin
      // Disparity would grow further: invert the data byte.
      active_sym = {1'b1, q_m_r[8], ~q_m_r[7:0]};
      cnt_next   = cnt + (q_m_r[8] ? 6'sd2 : 6'sd0) - diff;
    end else begin
      active_sym = {1'b0, q_m_r[8], q_m_r[7:0]};
      cnt_next   = cnt + diff - (q_m_r[8] ? 6'sd0 : 6'sd2);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      symbol <= CTL_SYM_00;
      cnt    <= '0;
    end else if (ce) begin
      if (blank_r) begin
        symbol <= ctl_symbol(ctl_r);
        cnt    <= '0;
      end else begin
        symbol <= active_sym;
        cnt    <= cnt_next;
      end
    end
  end
`else
  always_comb active_sym = {1'b0, q_m_r[8], q_m_r[7:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     symbol <= CTL_SYM_00;
    else if (ce)      symbol <= blank_r ? ctl_symbol(ctl_r) : active_sym;
  end
`endif

endmodule

// File: rtl/dvid_tmds_encoder.sv
// Parametrised multi-lane TMDS encoder for the DVI output path.
// Expands each lane's colour to 8 bits, routes sync onto lane 0 as control
// bits, and drives one tmds_channel_encoder per lane. Latency is two
// enabled clocks; blank_out is blank delayed to match.
// Parameters: CHANNELS (1..4), COLOUR_BITS (1..8)
// Ports:
//   clk, reset_n (async, active low), ce (clock enable)
//   hsync, vsync  lane-0 control bits c0, c1
//   blank         1 = control period
//   colour        lane i at [i*COLOUR_BITS +: COLOUR_BITS]
//   symbols       lane i at [i*10 +: 10]
//   clk_symbol    constant clock-lane pattern
//   blank_out     blank aligned with symbols
// Build option: DVID_DC_BALANCE_EN enables running-disparity DC balance.
module dvid_tmds_encoder
  import dvid_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int COLOUR_BITS = 8
)
(
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            ce,
  input  logic                            hsync,
  input  logic                            vsync,
  input  logic                            blank,
  input  logic [CHANNELS*COLOUR_BITS-1:0] colour,
  output logic [CHANNELS*SYM_W-1:0]       symbols,
  output logic [SYM_W-1:0]                clk_symbol,
  output logic                            blank_out
);

  assign clk_symbol = CLK_SYM;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    logic [COLOUR_BITS-1:0] raw;
    logic [7:0]             expanded;
    logic [1:0]             ctl;

    assign raw = colour[ch*COLOUR_BITS +: COLOUR_BITS];

    // Left-align and refill the low bits by repeating the value from its
    // MSB down, so full-scale input maps to full-scale output.
    for (genvar k = 0; k < 8; k++) begin : g_bit
      assign expanded[7-k] = raw[COLOUR_BITS-1-(k % COLOUR_BITS)];
    end

    if (ch == 0) begin : g_sync
      assign ctl = {vsync, hsync};
    end else begin : g_nosync
      assign ctl = 2'b00;
    end

    tmds_channel_encoder u_enc (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce),
      .ctl     (ctl),
      .data    (expanded),
      .blank   (blank),
      .symbol  (symbols[ch*SYM_W +: SYM_W])
    );
  end

  logic blank_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_d1  <= 1'b1;
      blank_out <= 1'b1;
    end else if (ce) begin
      blank_d1  <= blank;
      blank_out <= blank_d1;
    end
  end

endmodule

// File: tb/tb_dvid_tmds_encoder.sv
// Bench for dvid_tmds_encoder: a 3-lane 8-bit instance plus a 3-lane 3-bit
// instance sharing control inputs. Directed vectors push hand-computed
// expected symbols into a queue tagged with the enabled-edge count at which
// they must appear; a monitor pops and compares on the falling edge.
module tb_dvid_tmds_encoder;

`ifdef DVID_DC_BALANCE_EN
  localparam bit BAL = 1'b1;
`else
  localparam bit BAL = 1'b0;
`endif

  localparam int W = 62;  // {chk_narrow, blank_out, symbols[29:0], symbols_n[29:0]}

  localparam logic [9:0] C00  = 10'b1101010100;
  localparam logic [9:0] C01  = 10'b0010101011;
  localparam logic [9:0] C10  = 10'b0101010100;
  localparam logic [9:0] C11  = 10'b1010101011;
  localparam logic [9:0] CLKS = 10'b0000011111;

  // Hand-computed active symbols (lane0 = 8'h00, lane1 = 8'hFF, lane2 = 8'h55)
  localparam logic [9:0] S100 = 10'h100;
  localparam logic [9:0] S3FF = 10'h3FF;
  localparam logic [9:0] S200 = 10'h200;
  localparam logic [9:0] S0FF = 10'h0FF;
  localparam logic [9:0] S133 = 10'h133;
  localparam logic [9:0] L0_ALT   = BAL ? S3FF : S100;  // 00 when cnt<0
  localparam logic [9:0] FF_FIRST = BAL ? S200 : S0FF;  // FF with cnt=0
  localparam logic [23:0] PIX     = 24'h55FF00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ce, hsync, vsync, blank;
  logic [23:0] colour;
  logic [8:0]  colour_n;
  logic [29:0] symbols, symbols_n;
  logic [9:0]  clk_symbol, clk_symbol_n;
  logic        blank_out, blank_out_n;

  dvid_tmds_encoder #(.CHANNELS(3), .COLOUR_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .hsync(hsync), .vsync(vsync),
    .blank(blank), .colour(colour), .symbols(symbols),
    .clk_symbol(clk_symbol), .blank_out(blank_out)
  );

  dvid_tmds_encoder #(.CHANNELS(3), .COLOUR_BITS(3)) dut_n (
    .clk(clk), .reset_n(reset_n), .ce(ce), .hsync(hsync), .vsync(vsync),
    .blank(blank), .colour(colour_n), .symbols(symbols_n),
    .clk_symbol(clk_symbol_n), .blank_out(blank_out_n)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           en_edges = 0;
  bit           edge_en  = 1'b0;
  bit           edge_frz = 1'b0;
  bit           last_valid = 1'b0;
  logic [29:0]  last_exp = '0;
  int           rnd_lo = 1;
  int           rnd_hi = 0;

  always @(posedge clk) begin
    if (reset_n && ce) en_edges <= en_edges + 1;
    edge_en  <= reset_n && ce;
    edge_frz <= reset_n && !ce;
  end

  task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [9:0] ctl_sym(input logic vs, input logic hs);
    case ({vs, hs})
      2'b00:   return C00;
      2'b01:   return C01;
      2'b10:   return C10;
      default: return C11;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    bit           popped;
    popped = 1'b0;
    if (reset_n) begin
      while (due_q.size() > 0 && due_q[0] <= en_edges) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        popped = 1'b1;
        check("symbols", symbols, e[59:30]);
        check("blank_out", {29'd0, blank_out}, {29'd0, e[60]});
        check("blank_out_narrow", {29'd0, blank_out_n}, {29'd0, e[60]});
        if (e[61]) check("narrow_symbols", symbols_n, e[29:0]);
        last_exp   = e[59:30];
        last_valid = 1'b1;
      end
      if (edge_en && !popped) last_valid = 1'b0;
      if (edge_frz && last_valid) check("frozen_symbols", symbols, last_exp);
`ifndef DVID_DC_BALANCE_EN
      if (edge_en && en_edges >= rnd_lo && en_edges <= rnd_hi)
        check("unbalanced_bit9", {27'd0, symbols[29], symbols[19], symbols[9]}, 30'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic chk_n, input logic b,
                          input logic [29:0] sym, input logic [29:0] sym_n);
    exp_q.push_back({chk_n, b, sym, sym_n});
    due_q.push_back(en_edges + 2);
  endtask

  task automatic blank_px(input logic hs, input logic vs);
    @(posedge clk); #1;
    ce = 1'b1; blank = 1'b1; hsync = hs; vsync = vs;
    push_exp(1'b1, 1'b1, {C00, C00, ctl_sym(vs, hs)}, {C00, C00, ctl_sym(vs, hs)});
  endtask

  task automatic active_px(input logic [23:0] col, input logic [9:0] e0,
                           input logic [9:0] e1, input logic [9:0] e2,
                           input logic chk_n, input logic [9:0] en);
    @(posedge clk); #1;
    ce = 1'b1; blank = 1'b0; colour = col;
    push_exp(chk_n, 1'b0, {e2, e1, e0}, {en, en, en});
  endtask

  task automatic hold_px();
    @(posedge clk); #1;
    ce = 1'b0; colour = 24'($urandom_range(0, 24'hFFFFFF));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ce = 1'b1; blank = 1'b1; hsync = 1'b0; vsync = 1'b0;
    colour = '0; colour_n = 9'h1FF; reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_symbols", symbols, {C00, C00, C00});
    check("reset_blank_out", {29'd0, blank_out}, 30'd1);
    check("reset_narrow_symbols", symbols_n, {C00, C00, C00});
    check("clk_symbol_in_reset", {20'd0, clk_symbol}, {20'd0, CLKS});

    // cold start: hsync=1 during blank -> lane 0 carries control 01
    hsync = 1'b1; vsync = 1'b0; blank = 1'b1;
    reset_n = 1'b1;
    push_exp(1'b1, 1'b1, {C00, C00, C01}, {C00, C00, C01});
    blank_px(1'b1, 1'b0);
    blank_px(1'b1, 1'b0);

    // running disparity from cnt=0
    active_px(PIX, S100,   FF_FIRST, S133, 1'b1, FF_FIRST);
    active_px(PIX, L0_ALT, S0FF,     S133, 1'b0, S0FF);
    active_px(PIX, S100,   S0FF,     S133, 1'b0, S0FF);

    // clock enable low mid-line with changing data
    repeat (5) hold_px();
    active_px(PIX, L0_ALT, FF_FIRST, S133, 1'b0, S0FF);
    active_px(PIX, S100,   S0FF,     S133, 1'b0, S0FF);

    // blank with the other sync combinations, then first pixel restarts at cnt=0
    blank_px(1'b0, 1'b1);
    blank_px(1'b1, 1'b1);
    blank_px(1'b0, 1'b0);
    active_px(PIX, S100,   FF_FIRST, S133, 1'b1, FF_FIRST);
    active_px(PIX, L0_ALT, S0FF,     S133, 1'b0, S0FF);

    // asynchronous reset between edges while lane disparity is non-zero
    @(posedge clk); #3;
    exp_q.delete(); due_q.delete(); last_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midline_reset_symbols", symbols, {C00, C00, C00});
    check("midline_reset_blank_out", {29'd0, blank_out}, 30'd1);
    check("clk_symbol_midline_reset", {20'd0, clk_symbol_n}, {20'd0, CLKS});
    ce = 1'b1; blank = 1'b0; colour = PIX; hsync = 1'b0; vsync = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b1;
    push_exp(1'b1, 1'b0, {S133, FF_FIRST, S100}, {FF_FIRST, FF_FIRST, FF_FIRST});
    active_px(PIX, L0_ALT, S0FF, S133, 1'b0, S0FF);

`ifndef DVID_DC_BALANCE_EN
    // random active data: top bit must stay clear without balancing
    rnd_lo = en_edges + 3;
    rnd_hi = en_edges + 1 + 16 + 1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      ce = 1'b1; blank = 1'b0;
      colour = 24'($urandom_range(0, 24'hFFFFFF));
    end
`endif

    blank_px(1'b0, 1'b0);
    blank_px(1'b0, 1'b0);
    blank_px(1'b0, 1'b0);

    for (int i = 0; i < 20 && due_q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (due_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected symbols never appeared, required 0", due_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dvid_tmds_encoder.md
# dvid_tmds_encoder

Parametrised TMDS 8b/10b encoder replacing the fixed 3-bit lookup encoder in the DVI output path. Encodes CHANNELS colour lanes with full transition minimisation and running-disparity DC balance, and emits control symbols during blanking. Sits between the video timing generator and the 10:1 serialiser/LVDS stage, running in the pixel clock domain.

## Interface
- CHANNELS, 3: number of TMDS data lanes (1..4); lane 0 carries sync.
- COLOUR_BITS, 8: input bits per lane (1..8); narrower values expand to 8 bits.
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; low freezes the whole pipeline.
- hsync  in  1  horizontal sync, control bit c0 of lane 0.
- vsync  in  1  vertical sync, control bit c1 of lane 0.
- blank  in  1  1 = control period, 0 = active video.
- colour  in  CHANNELS*COLOUR_BITS  lane i at [i*COLOUR_BITS +: COLOUR_BITS].
- symbols  out  CHANNELS*10  lane i at [i*10 +: 10]; bit 0 transmitted first.
- clk_symbol  out  10  constant 10'b0000011111 for the clock lane.
- blank_out  out  1  blank delayed to align with symbols.

## Operation
- Expansion: a COLOUR_BITS value is left-aligned in 8 bits, with the low bits filled by repeating its MSBs (3'b101 -> 8'b10110110). COLOUR_BITS=8 passes through unchanged.
- Stage 1 (per lane, registered): compute q_m[8:0].
  - n1(d) = popcount of d.
  - If n1 > 4, or n1 == 4 with d[0] == 0, use the XNOR chain, else the XOR chain.
  - q_m[0] = d[0].
  - q_m[8] = 1 for XOR, 0 for XNOR.
  - Register q_m, n1(q_m[7:0]), blank and ctl. Lane 0 ctl = {vsync, hsync}; other lanes ctl = 2'b00.
- Stage 2 (per lane, registered): running disparity cnt, 6-bit two's complement.
  - blank=1: emit the control symbol and set cnt to 0. Control symbols are 00 -> 10'b1101010100, 01 -> 10'b0010101011, 10 -> 10'b0101010100, 11 -> 10'b1010101011.
  - cnt == 0 or n1 == n0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? (n1-n0) : (n0-n1).
  - (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1): out = {1, q_m[8], ~q_m[7:0]}. cnt += 2*q_m[8] + (n0-n1).
  - Otherwise: out = {0, q_m[8], q_m[7:0]}. cnt += -2*(~q_m[8]) + (n1-n0).
- Lanes are independent. Each lane keeps its own cnt.
- The clk_symbol output is combinational constant and is not affected by reset.

## Timing
- Latency is 2 enabled cycles from colour/blank/sync to symbols/blank_out.
- ce=0: all pipeline registers and cnt hold their values, and outputs are stable. On ce=1, processing resumes with no data lost.
- No backpressure. The stream is continuous and one symbol per lane per enabled cycle.
- Reset (asynchronous assert, even mid-frame) forces:
  - symbols to 10'b1101010100 on every lane;
  - blank_out = 1;
  - cnt = 0;
  - stage-1 registers to the blank, ctl=00 state.
- After reset, valid data appears on the second enabled edge following the deassertion of reset_n.
- A blank transition in either direction takes effect on the symbol exactly 2 enabled cycles later. The first active pixel after blank always starts with cnt = 0.

## Configuration
- DVID_DC_BALANCE_EN defined: full running-disparity logic as above.
- DVID_DC_BALANCE_EN undefined:
  - cnt registers and the compare logic are removed.
  - Active symbols are {1'b0, q_m[8], q_m[7:0]}.
  - The output is still decodable but not DC-balanced.
  - Control symbols, latency and reset values are unchanged.

## Structure
- dvid_pkg holds:
  - the four control symbol constants;
  - the clock symbol constant;
  - the symbol width (10);
  - the cnt width (6).
- Sub-module tmds_channel_encoder is the two-stage single-lane encoder (ctl, 8-bit data, blank, ce in; 10-bit symbol out). It is instantiated CHANNELS times in a generate loop. The top holds expansion, sync routing and blank_out.

## Test plan
- Reset → outputs and cold start: hold reset_n low → every lane is 10'b1101010100, blank_out=1. Then release reset_n with blank=1, hsync=1, vsync=0 → after 2 cycles lane 0 = 10'b0010101011 and lanes 1-2 = 10'b1101010100.
- Running disparity: blank=0, lane data 8'h00 for 3 cycles (balance enabled) → symbols 10'h100, 10'h3FF, 10'h100. cnt sequence is -8, +2, -6.
- Narrow input: COLOUR_BITS=3, colour 3'b111 on all lanes → stage-1 input 8'hFF, and the first active symbol is 10'b1000000000 (0x200) after a blank.
- Clock enable: hold ce=0 for 5 cycles mid-line while the data input changes → symbols and cnt are frozen. After ce=1, the output sequence matches a ce-always-high reference run.
- Reset mid-line: assert reset_n low asynchronously between edges while cnt ≠ 0 → symbols go to 10'b1101010100 immediately. After release, the first active 8'h00 produces 10'h100.
- Balance disabled: build without DVID_DC_BALANCE_EN and send 3 × 8'h00 → 10'h100 each cycle. Random data → bit 9 always 0.
